// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD number formatter and the LCD print sequencer.
package lcd_pkg;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   // State encoding of the formatter FSM
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_WRITE   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Characters per LCD line, shared with the print sequencer
   localparam int LCD_LINE_LEN = 16;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_CONVERT = ST_CONVERT,
      S_WRITE   = ST_WRITE,
      S_DONE    = ST_DONE
   } fmt_state_t;

   // ASCII for one decimal digit, or a space when the digit is a blanked leading zero
   function automatic logic [7:0] digit_char(input logic [3:0] digit, input logic blank);
      return blank ? ASCII_SPACE : (ASCII_ZERO + {4'h0, digit});
   endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5, then shift the
// whole BCD vector left by one, taking the next binary bit in at the bottom.
module bcd_dabble_step #(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] i_bcd,
   input  logic                i_bit,
   output logic [4*DIGITS-1:0] o_bcd
);

   // The MSB of the top nibble is shifted out and is always zero when the
   // digit count is sized for the input width, so only 3 bits of it are kept.
   logic [4*DIGITS-2:0] w_adj;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
         if (gi < DIGITS - 1) begin : g_low
            assign w_adj[4*gi +: 4] = (i_bcd[4*gi +: 4] >= 4'd5) ?
                                      (i_bcd[4*gi +: 4] + 4'd3) : i_bcd[4*gi +: 4];
         end else begin : g_top
            assign w_adj[4*gi +: 3] = (i_bcd[4*gi +: 4] >= 4'd5) ?
                                      (i_bcd[4*gi +: 3] + 3'd3) : i_bcd[4*gi +: 3];
         end
      end
   endgenerate

   assign o_bcd = {w_adj, i_bit};

endmodule

// File: rtl/lcd_num_formatter.sv
// Binary to right-aligned decimal ASCII formatter feeding the LCD print
// sequencer. Iterative double-dabble (one bit per cycle) followed by a
// one-character-per-cycle write pass with leading-zero blanking.
module lcd_num_formatter #(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter int LINE_LEN = lcd_pkg::LCD_LINE_LEN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   input  logic [4:0]       rd_addr,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             done,
   output logic             lcd_start
);

   import lcd_pkg::*;

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int D_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int IDX_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int BASE  = LINE_LEN - DIGITS;

   fmt_state_t       r_state;
   fmt_state_t       w_state_next;
   logic [WIDTH-1:0] r_shift;
   logic [BCD_W-1:0] r_bcd;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [D_W-1:0]   r_d;
   logic             r_lead;
   logic [7:0]       r_line [LINE_LEN];

   logic [BCD_W-1:0] w_bcd_step;
   logic [3:0]       w_dig [DIGITS];
   logic [3:0]       w_digit;
   logic             w_last_digit;
   logic             w_blank;
   logic [7:0]       w_char;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_wr_en;

   bcd_dabble_step #(
      .DIGITS (DIGITS)
   ) u_step (
      .i_bcd (r_bcd),
      .i_bit (r_shift[WIDTH-1]),
      .o_bcd (w_bcd_step)
   );

   // Digit 0 is the most significant nibble of the BCD register
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_dig[gi] = r_bcd[4*(DIGITS-1-gi) +: 4];
      end
   endgenerate

   assign w_digit      = w_dig[r_d];
   assign w_last_digit = (r_d == D_W'(DIGITS - 1));
   assign w_blank      = r_lead && (w_digit == 4'd0) && !w_last_digit;
   assign w_char       = digit_char(w_digit, w_blank);
   assign w_wr_idx     = IDX_W'(BASE + int'(r_d));
   assign w_wr_en      = (r_state == S_WRITE);

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign lcd_start = (r_state == S_DONE);

   assign rd_data = (int'(rd_addr) < LINE_LEN) ? r_line[rd_addr[IDX_W-1:0]] : ASCII_SPACE;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; load is only looked at in IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:    if (load) w_state_next = S_CONVERT;
         S_CONVERT: if (r_bit_cnt == CNT_W'(1)) w_state_next = S_WRITE;
         S_WRITE:   if (w_last_digit) w_state_next = S_DONE;
         S_DONE:    w_state_next = S_IDLE;
         default:   w_state_next = S_IDLE;
      endcase
   end

   // Conversion datapath: capture, shift-and-adjust, then walk the digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift   <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
         r_d       <= '0;
         r_lead    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load) begin
                  r_shift   <= value;
                  r_bcd     <= '0;
                  r_bit_cnt <= CNT_W'(WIDTH);
               end
            end
            S_CONVERT: begin
               r_bcd     <= w_bcd_step;
               r_shift   <= r_shift << 1;
               r_bit_cnt <= r_bit_cnt - 1'b1;
               r_d       <= '0;
               r_lead    <= 1'b1;
            end
            S_WRITE: begin
               r_lead <= r_lead && (w_digit == 4'd0);
               if (!w_last_digit) begin
                  r_d <= r_d + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Line buffer: reset to spaces, one character written per WRITE cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LINE_LEN; i++) begin
            r_line[i] <= ASCII_SPACE;
         end
      end else if (w_wr_en) begin
         r_line[w_wr_idx] <= w_char;
      end
   end

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Scoreboard bench for lcd_num_formatter: accepted loads push expected jobs,
// a negedge monitor checks busy/done/lcd_start every cycle and the line buffer
// on each done pulse against a printf-style reference line.
module tb_lcd_num_formatter;

   localparam int WIDTH    = 16;
   localparam int DIGITS   = 5;
   localparam int LINE_LEN = 16;
   localparam int DONE_OFS = WIDTH + DIGITS;  // edges from accept to DONE state
   localparam int NEXT_OFS = WIDTH + DIGITS + 2;  // edges from accept to next accept

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [4:0]  rd_addr = '0;
   logic [7:0]  rd_data;
   logic        busy;
   logic        done;
   logic        lcd_start;

   typedef struct {
      int unsigned val;
      int          acc;
   } job_t;

   job_t sb_q[$];
   int   cyc = 0;
   int   free_edge = 0;
   int   checks = 0;
   int   errors = 0;
   int   blank_req = 0;
   int   blank_seen = 0;

   lcd_num_formatter #(
      .WIDTH    (WIDTH),
      .DIGITS   (DIGITS),
      .LINE_LEN (LINE_LEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .value     (value),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .lcd_start (lcd_start)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference line: blanks, then the value right-aligned in DIGITS columns
   function automatic string exp_line(input int unsigned v, input bit blank_only);
      string s;
      s = "";
      for (int i = 0; i < LINE_LEN - DIGITS; i++) s = {s, " "};
      if (blank_only) begin
         for (int i = 0; i < DIGITS; i++) s = {s, " "};
      end else begin
         s = {s, $sformatf("%5d", v)};
      end
      return s;
   endfunction

   task automatic sweep(input string name, input string exp);
      int         bad_addr;
      logic [7:0] bad_got;
      logic [7:0] bad_exp;
      logic [7:0] ec;
      bad_addr = -1;
      bad_got = '0;
      bad_exp = '0;
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a);
         #1;
         ec = (a < LINE_LEN) ? exp[a] : 8'h20;
         if (rd_data !== ec && bad_addr < 0) begin
            bad_addr = a;
            bad_got  = rd_data;
            bad_exp  = ec;
         end
      end
      checks++;
      if (bad_addr >= 0) begin
         errors++;
         $display("FAIL %s at cycle %0d addr %0d: got %02h expected %02h line \"%s\"",
                  name, cyc, bad_addr, bad_got, bad_exp, exp);
      end
   endtask

   // Cycle counter and acceptance model: a load is taken when the block is idle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         free_edge <= 0;
      end else if (load && (cyc + 1 >= free_edge)) begin
         job_t j;
         j.val = value;
         j.acc = cyc + 1;
         sb_q.push_back(j);
         $display("accept value=%0d at edge %0d", value, cyc + 1);
         free_edge <= cyc + 1 + NEXT_OFS;
      end
   end

   // Monitor: per-cycle status checks, line check on every done pulse
   always @(negedge clk) begin : mon
      bit   eb;
      bit   ed;
      job_t j;
      if (rst) begin
         sb_q.delete();
         chk("busy_in_reset", 32'(busy), 32'd0);
         chk("done_in_reset", 32'(done), 32'd0);
         chk("start_in_reset", 32'(lcd_start), 32'd0);
      end else begin
         eb = (sb_q.size() > 0) && (cyc >= sb_q[0].acc) && (cyc <= sb_q[0].acc + DONE_OFS);
         ed = (sb_q.size() > 0) && (cyc == sb_q[0].acc + DONE_OFS);
         chk("busy", 32'(busy), 32'(eb));
         chk("done", 32'(done), 32'(ed));
         chk("lcd_start", 32'(lcd_start), 32'(ed));
         if (ed) begin
            j = sb_q.pop_front();
            sweep("line", exp_line(j.val, 1'b0));
            $display("done value=%0d accepted %0d done %0d", j.val, j.acc, cyc);
         end else if (blank_req != blank_seen) begin
            sweep("blank_line", exp_line(0, 1'b1));
            blank_seen = blank_req;
         end
      end
   end

   task automatic conv(input int unsigned v);
      while (cyc + 1 < free_edge) @(negedge clk);
      value = 16'(v);
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      blank_req++;
      repeat (50) @(negedge clk);

      conv(0);
      conv(1234);
      conv(65535);
      conv(100);
      conv(9);
      conv(10);
      conv(99);
      conv(10000);

      // load held high through busy and DONE
      while (cyc + 1 < free_edge) @(negedge clk);
      value = 16'd7;
      load  = 1'b1;
      repeat (60) @(negedge clk);
      load  = 1'b0;
      repeat (30) @(negedge clk);

      // reset during cycle 10 of a conversion
      conv(40000);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("busy_after_rst", 32'(busy), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      blank_req++;
      repeat (40) @(negedge clk);

      for (int k = 0; k < 25; k++) begin
         conv($urandom_range(0, 65535));
         repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      conv(65535);
      conv(100);

      repeat (30) @(negedge clk);
      chk("queue_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
